// File: rtl/texture_stream_source.sv
// rtl/texture_stream_source.sv - streams a contiguous run of texture memory words out as stream beats
module texture_stream_source #(
    parameter int STREAM_WIDTH = 32,
    parameter int ADDR_WIDTH   = 16
) (
    input  logic                    aclk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [ADDR_WIDTH:0]     cmd_beats,
    output logic                    mem_rd_en,
    output logic [ADDR_WIDTH-1:0]   mem_rd_addr,
    input  logic [STREAM_WIDTH-1:0] mem_rd_data,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic [STREAM_WIDTH-1:0] m_axis_tdata,
    output logic                    busy
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;

    logic [0:0]              state;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [ADDR_WIDTH:0]     rd_left;
    logic                    inflight;
    logic                    inflight_last;
    logic [STREAM_WIDTH-1:0] fifo_data [2];
    logic [1:0]              fifo_last;
    logic                    wr_ptr;
    logic                    rd_ptr;
    logic [1:0]              count;
    logic                    pop;
    logic [1:0]              committed;
    logic                    rd_go;

    always_comb begin
        cmd_ready     = !reset && (state == S_IDLE);
        busy          = !reset && (state == S_STREAM);
        m_axis_tvalid = !reset && (count != 2'd0);
        m_axis_tdata  = reset ? '0 : fifo_data[rd_ptr];
        m_axis_tlast  = m_axis_tvalid && fifo_last[rd_ptr];
        pop           = m_axis_tvalid && m_axis_tready;
        // A slot freed by this cycle's pop may be claimed by a new read, which
        // keeps one beat per cycle while never exceeding two buffered words.
        committed     = count - {1'b0, pop} + {1'b0, inflight};
        rd_go         = busy && (rd_left != '0) && (committed < 2'd2);
        mem_rd_en     = rd_go;
        mem_rd_addr   = reset ? '0 : rd_addr;
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            state         <= S_IDLE;
            rd_addr       <= '0;
            rd_left       <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            fifo_data[0]  <= '0;
            fifo_data[1]  <= '0;
            fifo_last     <= 2'b00;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            count         <= 2'd0;
        end else begin
            if (state == S_IDLE) begin
                if (cmd_valid && (cmd_beats != '0)) begin
                    state   <= S_STREAM;
                    rd_addr <= cmd_addr;
                    rd_left <= cmd_beats;
                end
            end else if (pop && m_axis_tlast) begin
                state <= S_IDLE;
            end

            if (rd_go) begin
                rd_addr <= rd_addr + ADDR_WIDTH'(1);
                rd_left <= rd_left - (ADDR_WIDTH + 1)'(1);
            end
            inflight      <= rd_go;
            inflight_last <= rd_go && (rd_left == (ADDR_WIDTH + 1)'(1));

            if (inflight) begin
                fifo_data[wr_ptr] <= mem_rd_data;
                fifo_last[wr_ptr] <= inflight_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, inflight} - {1'b0, pop};
        end
    end

endmodule
